axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 OUTS_MAX, default 8: max outstanding B responses per requester, legal range 1..15.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 m{0,1}_awaddr  in  32  write address; m0 = write-buffer line drain, m1 = uncached store path.
REQ-005 m{0,1}_awlen  in  4  burst length minus 1.
REQ-006 m{0,1}_awvalid  in  1  address request; held with awaddr/awlen/wdata stable until accepted.
REQ-007 m{0,1}_awready  out  1  address accepted.
REQ-008 m{0,1}_wdata  in  32  write beat data.
REQ-009 m{0,1}_wstrb  in  4  byte strobes.
REQ-010 m{0,1}_wvalid  in  1  beat valid.
REQ-011 m{0,1}_wready  out  1  beat accepted.
REQ-012 m{0,1}_bvalid  out  1  one-cycle pulse per completed write of that requester.
REQ-013 awid  out  4  {3'b0, grant}.
REQ-014 awaddr  out  32  granted address, 0 when not in ADDR.
REQ-015 awlen  out  4  granted length.
REQ-016 awsize/awburst/awlock/awcache/awprot  out  3/2/2/4/3  constants 3'b010, 2'b01, 0, 0, 0.
REQ-017 awvalid  out  1  address valid.
REQ-018 awready  in  1  slave address ready.
REQ-019 wid  out  4  {3'b0, grant}.
REQ-020 wdata / wstrb  out  32/4  granted beat data and strobes, 0 outside DATA.
REQ-021 wlast  out  1  generated internally; requesters supply no wlast.
REQ-022 wvalid  out  1  beat valid.
REQ-023 wready  in  1  slave beat ready.
REQ-024 bid  in  4  response ID; only bid[0] decoded; bid[3:1] and bresp ignored.
REQ-025 bvalid  in  1; bready  out  1, tied to 1.
REQ-026 idle  out  1  high when FSM is in IDLE and both pending counters are 0.

Function
REQ-027 FSM states IDLE, ADDR, DATA; 1-bit grant register; 1-bit last_grant register; 4-bit beat counter; 4-bit bpend0/bpend1 counters.
REQ-028 Eligibility: requester k is eligible iff m{k}_awvalid=1 and bpend{k} < OUTS_MAX.
REQ-029 Arbitration in IDLE:
- If exactly one requester is eligible, it is granted.
- If both are eligible, the requester not equal to last_grant is granted (round-robin).
- The granted requester is registered and the FSM moves to ADDR next cycle.
- In IDLE, all AXI valids and all m awready/wready outputs are 0.
REQ-030 ADDR:
- awvalid=1 and awaddr/awlen come combinationally from the granted requester.
- m{grant}_awready = awready; the other requester's awready = 0.
- On awready=1: bpend{grant} increments, beat counter clears, FSM moves to DATA.
REQ-031 DATA:
- wvalid = m{grant}_wvalid; wready is forwarded to the granted requester only.
- Each wvalid&wready handshake increments the beat counter.
- wlast=1 when beat counter == captured awlen.
- On a wlast handshake: FSM returns to IDLE and last_grant <= grant.
REQ-032 Latency: AXI awvalid rises 1 cycle after request in IDLE. Minimum single-beat write occupancy is 3 cycles (IDLE, ADDR, DATA). Back-to-back grants have exactly 1 IDLE cycle between them.
REQ-033 B routing:
- bvalid with bid[0]=k pulses m{k}_bvalid in the same cycle and decrements bpend{k}.
- A decrement at 0 saturates at 0; the pulse is still forwarded.
REQ-034 Simultaneous increment and decrement of the same bpend counter leaves it unchanged.
REQ-035 A requester at OUTS_MAX is skipped, not stalled on. The other requester may be granted even when it was last_grant.

Reset
REQ-036 rst=1 at any cycle, including mid-burst:
- Next cycle: FSM=IDLE, grant=0, last_grant=0 (m1 wins the first tie), beat counter=0, bpend0=bpend1=0.
- All valid/ready outputs are 0 except bready=1; idle=1.

Verification
REQ-037 Single m1 write (awaddr=0x1FC00010, awlen=0), awready/wready always 1 -> awvalid at cycle 1, awid=1, wvalid+wlast at cycle 2, bid=1 response pulses m1_bvalid only, idle returns 1.
REQ-038 m0 8-beat burst (awlen=7) with wready low on beats 3 and 6 -> exactly 8 handshakes, wlast only on the 8th, m1_wready stays 0 throughout.
REQ-039 Both requesters request continuously from reset -> grant order m1, m0, m1, m0; each AW separated by one IDLE cycle.
REQ-040 OUTS_MAX=2, m0 bursts with bvalid withheld -> third m0 request not granted while m1 is still granted; first bid=0 response re-enables m0 next IDLE.
REQ-041 bvalid (bid=0) coincident with an m0 AW handshake at bpend0=1 -> bpend0 stays 1; bvalid with bpend1=0 -> m1_bvalid pulses, counter stays 0.
REQ-042 rst asserted during beat 4 of an 8-beat burst -> next cycle all valids 0, idle=1, counters 0; a subsequent m1 request is granted normally.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write-channel arbiter: round-robin address grant, one burst in flight,
// per-requester outstanding-response limit and B-channel routing on bid[0].
module axi_wr_arbiter #(
    parameter int unsigned OUTS_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_awaddr,
    input  logic [3:0]  m0_awlen,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic        m0_bvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awlen,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        idle
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [3:0] OUTS_LIM = 4'(OUTS_MAX);

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [3:0]  beat_cnt;
    logic [3:0]  len_q;
    logic [3:0]  bpend0;
    logic [3:0]  bpend1;

    logic        elig0, elig1;
    logic        in_addr, in_data;
    logic        w_hs;
    logic        inc0, inc1, dec0, dec1;
    logic [31:0] g_awaddr, g_wdata;
    logic [3:0]  g_awlen, g_wstrb;
    logic        g_wvalid;
    logic        unused_bits;

    // A requester sitting at its outstanding limit is skipped rather than waited on.
    assign elig0 = m0_awvalid && (bpend0 < OUTS_LIM);
    assign elig1 = m1_awvalid && (bpend1 < OUTS_LIM);

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    assign g_awaddr = grant ? m1_awaddr : m0_awaddr;
    assign g_awlen  = grant ? m1_awlen  : m0_awlen;
    assign g_wdata  = grant ? m1_wdata  : m0_wdata;
    assign g_wstrb  = grant ? m1_wstrb  : m0_wstrb;
    assign g_wvalid = grant ? m1_wvalid : m0_wvalid;

    assign awid    = {3'b000, grant};
    assign awaddr  = in_addr ? g_awaddr : 32'd0;
    assign awlen   = in_addr ? g_awlen : 4'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = in_addr;

    assign m0_awready = in_addr && !grant && awready;
    assign m1_awready = in_addr && grant && awready;

    assign wid    = {3'b000, grant};
    assign wdata  = in_data ? g_wdata : 32'd0;
    assign wstrb  = in_data ? g_wstrb : 4'd0;
    assign wvalid = in_data && g_wvalid;
    assign wlast  = in_data && (beat_cnt == len_q);
    assign w_hs   = wvalid && wready;

    assign m0_wready = in_data && !grant && wready;
    assign m1_wready = in_data && grant && wready;

    assign bready    = 1'b1;
    assign m0_bvalid = bvalid && !bid[0];
    assign m1_bvalid = bvalid && bid[0];

    assign inc0 = in_addr && awready && !grant;
    assign inc1 = in_addr && awready && grant;
    assign dec0 = bvalid && !bid[0];
    assign dec1 = bvalid && bid[0];

    assign idle = (state == IDLE) && (bpend0 == 4'd0) && (bpend1 == 4'd0);

    assign unused_bits = ^{bid[3:1], bresp};

    // Coincident issue and retire cancel; a stray response never wraps the count.
    function automatic logic [3:0] pend_next(input logic [3:0] cur, input logic inc,
                                             input logic dec);
        if (inc && !dec)
            return cur + 4'd1;
        if (dec && !inc && (cur != 4'd0))
            return cur - 4'd1;
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            beat_cnt   <= 4'd0;
            len_q      <= 4'd0;
            bpend0     <= 4'd0;
            bpend1     <= 4'd0;
        end else begin
            bpend0 <= pend_next(bpend0, inc0, dec0);
            bpend1 <= pend_next(bpend1, inc1, dec1);
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant <= (elig0 && elig1) ? !last_grant : elig1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        beat_cnt <= 4'd0;
                        len_q    <= g_awlen;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (wlast) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: per-ID scoreboard queues filled by the requester
// drivers and drained by a bus monitor, plus cycle-accurate checks of grant order and latency.
module tb_axi_wr_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [3:0]  m0_awlen, m1_awlen, m0_wstrb, m1_wstrb;
    logic        m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid;
    logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
    logic [3:0]  awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, idle;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } aw_t;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    aw_t awq0[$], awq1[$];
    w_t  wq0[$], wq1[$];
    logic [3:0] aw_ids[$];
    int  aw_cycs[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  w_hs = 0;
    int  wlast_cnt = 0;
    int  w_last_cyc = 0;
    int  rc;
    logic mon_on = 1'b0;
    logic watch_m1w = 1'b0;
    logic abort = 1'b0;
    aw_t exp_a;
    w_t  exp_w;

    axi_wr_arbiter #(.OUTS_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awvalid(m0_awvalid),
        .m0_awready(m0_awready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid),
        .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awvalid(m1_awvalid),
        .m1_awready(m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (!awvalid) chk("awaddr_outside_addr", awaddr, 64'd0);
            if (watch_m1w) chk("m1_wready_quiet", m1_wready, 64'd0);
            if (awvalid && awready) begin
                aw_ids.push_back(awid);
                aw_cycs.push_back(cyc);
                chk("aw_attr", {awsize, awburst, awlock, awcache, awprot}, 14'b010_01_00_0000_000);
                if ((awid[0] && awq1.size() == 0) || (!awid[0] && awq0.size() == 0))
                    chk("aw_unexpected", awvalid, 64'd0);
                else begin
                    if (awid[0]) exp_a = awq1.pop_front();
                    else exp_a = awq0.pop_front();
                    chk("aw_addr_len", {awaddr, awlen}, {exp_a.addr, exp_a.len});
                end
            end
            if (wvalid && wready) begin
                w_hs++;
                w_last_cyc = cyc;
                if (wlast) wlast_cnt++;
                if ((wid[0] && wq1.size() == 0) || (!wid[0] && wq0.size() == 0))
                    chk("w_unexpected", wvalid, 64'd0);
                else begin
                    if (wid[0]) exp_w = wq1.pop_front();
                    else exp_w = wq0.pop_front();
                    chk("w_beat", {wdata, wstrb, wlast}, {exp_w.data, exp_w.strb, exp_w.last});
                end
            end
        end
    end

    function automatic logic awrdy(input int k);
        return (k == 1) ? m1_awready : m0_awready;
    endfunction

    function automatic logic wrdy(input int k);
        return (k == 1) ? m1_wready : m0_wready;
    endfunction

    task automatic set_aw(input int k, input logic v, input logic [31:0] a, input logic [3:0] l);
        if (k == 1) begin m1_awvalid = v; m1_awaddr = a; m1_awlen = l; end
        else begin m0_awvalid = v; m0_awaddr = a; m0_awlen = l; end
    endtask

    task automatic set_w(input int k, input logic v, input logic [31:0] d, input logic [3:0] s);
        if (k == 1) begin m1_wvalid = v; m1_wdata = d; m1_wstrb = s; end
        else begin m0_wvalid = v; m0_wdata = d; m0_wstrb = s; end
    endtask

    // Called just after a rising edge; returns just after the rising edge following the last beat.
    task automatic drive_write(input int k, input logic [31:0] addr, input logic [3:0] len);
        aw_t a;
        w_t  w;
        int  t;
        a.addr = addr;
        a.len  = len;
        if (k == 1) awq1.push_back(a); else awq0.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
            w.data = addr + 32'(b);
            w.strb = 4'hF ^ 4'(b);
            w.last = (b == int'(len));
            if (k == 1) wq1.push_back(w); else wq0.push_back(w);
        end
        set_aw(k, 1'b1, addr, len);
        t = 0;
        do begin @(negedge clk); t++; end while (!awrdy(k) && t < 200 && !abort);
        if (!awrdy(k) && !abort) chk("aw_timeout", awrdy(k), 64'd1);
        if (abort || !awrdy(k)) begin
            set_aw(k, 1'b0, 32'd0, 4'd0);
            return;
        end
        @(posedge clk); #1;
        set_aw(k, 1'b0, 32'd0, 4'd0);
        for (int b = 0; b <= int'(len); b++) begin
            set_w(k, 1'b1, addr + 32'(b), 4'hF ^ 4'(b));
            t = 0;
            do begin @(negedge clk); t++; end while (!wrdy(k) && t < 200 && !abort);
            if (abort) break;
            if (!wrdy(k)) begin
                chk("w_timeout", wrdy(k), 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        set_w(k, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic send_b(input int k);
        bvalid = 1'b1;
        bid    = (k == 1) ? 4'b1011 : 4'b1010;
        @(negedge clk);
        chk("b_route", {m0_bvalid, m1_bvalid}, (k == 1) ? 64'd1 : 64'd2);
        @(posedge clk); #1;
        bvalid = 1'b0;
    endtask

    task automatic clear_rec();
        aw_ids.delete();
        aw_cycs.delete();
        w_hs = 0;
        wlast_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bvalid = 1'b0;
        set_aw(0, 1'b0, 32'd0, 4'd0);
        set_aw(1, 1'b0, 32'd0, 4'd0);
        set_w(0, 1'b0, 32'd0, 4'd0);
        set_w(1, 1'b0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        awq0.delete(); awq1.delete(); wq0.delete(); wq1.delete();
        clear_rec();
    endtask

    task automatic chk_aw(input string tag, input int idx, input logic [3:0] id, input int c);
        if (idx >= aw_ids.size())
            chk({tag, "_missing"}, aw_ids.size(), 64'(idx + 1));
        else begin
            chk({tag, "_id"}, aw_ids[idx], id);
            chk({tag, "_cycle"}, aw_cycs[idx], 64'(c));
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, idle, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bid = 4'd0; bresp = 2'b10;
        set_aw(0, 1'b0, 32'd0, 4'd0); set_aw(1, 1'b0, 32'd0, 4'd0);
        set_w(0, 1'b0, 32'd0, 4'd0);  set_w(1, 1'b0, 32'd0, 4'd0);
        mon_on = 1'b1;
        do_reset();
        @(negedge clk);
        chk("reset_state", {idle, bready, awvalid, wvalid, wlast, m0_awready, m1_awready,
                            m0_wready, m1_wready}, 9'b11_0000000);
        @(posedge clk); #1;

        // single m1 write
        rc = cyc;
        drive_write(1, 32'h1FC0_0010, 4'd0);
        chk_aw("t1_aw", 0, 4'd1, rc + 1);
        chk("t1_w_cycle", w_last_cyc, 64'(rc + 2));
        chk_idle("t1_busy", 1'b0);
        send_b(1);
        chk_idle("t1_idle", 1'b1);

        // m0 8-beat burst with two slave stalls
        do_reset();
        watch_m1w = 1'b1;
        fork
            drive_write(0, 32'h8000_0100, 4'd7);
            begin : stall_p
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!(awvalid && awready) && t < 100);
                repeat (3) @(posedge clk);
                #1 wready = 1'b0;
                @(posedge clk); #1 wready = 1'b1;
                repeat (3) @(posedge clk);
                #1 wready = 1'b0;
                @(posedge clk); #1 wready = 1'b1;
            end
        join
        watch_m1w = 1'b0;
        chk("t38_handshakes", w_hs, 64'd8);
        chk("t38_wlast_count", wlast_cnt, 64'd1);
        send_b(0);
        chk_idle("t38_idle", 1'b1);

        // both requesters continuously from reset
        do_reset();
        rc = cyc;
        fork
            begin drive_write(1, 32'h1000_0000, 4'd0); drive_write(1, 32'h1000_0040, 4'd0); end
            begin drive_write(0, 32'h2000_0000, 4'd0); drive_write(0, 32'h2000_0040, 4'd0); end
        join
        chk_aw("t39_g0", 0, 4'd1, rc + 1);
        chk_aw("t39_g1", 1, 4'd0, rc + 4);
        chk_aw("t39_g2", 2, 4'd1, rc + 7);
        chk_aw("t39_g3", 3, 4'd0, rc + 10);
        send_b(1); send_b(1); send_b(0); send_b(0);
        chk_idle("t39_idle", 1'b1);

        // outstanding limit of 2 on m0
        do_reset();
        drive_write(0, 32'h3000_0000, 4'd0);
        drive_write(0, 32'h3000_0040, 4'd0);
        clear_rec();
        rc = cyc;
        fork
            drive_write(0, 32'h3000_0080, 4'd0);
            begin drive_write(1, 32'h4000_0000, 4'd0); drive_write(1, 32'h4000_0040, 4'd0); end
            begin : b40_p
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (aw_ids.size() < 2 && t < 100);
                @(posedge clk); #1;
                rc = cyc;
                send_b(0);
            end
        join
        chk_aw("t40_g0", 0, 4'd1, aw_cycs.size() > 0 ? aw_cycs[0] : -1);
        chk_aw("t40_g1", 1, 4'd1, aw_cycs.size() > 1 ? aw_cycs[1] : -1);
        chk_aw("t40_g2", 2, 4'd0, rc + 2);

        // coincident increment/decrement and saturation at zero
        do_reset();
        drive_write(0, 32'h5000_0000, 4'd0);
        fork
            drive_write(0, 32'h5000_0040, 4'd0);
            begin : coin_p
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!(awvalid && awid == 4'd0) && t < 100);
                bvalid = 1'b1;
                bid = 4'b0000;
                #1;
                chk("t41_coincide_aw", m0_awready, 64'd1);
                chk("t41_b_route", {m0_bvalid, m1_bvalid}, 64'd2);
                @(posedge clk); #1 bvalid = 1'b0;
            end
        join
        chk_idle("t41_pend_kept", 1'b0);
        send_b(0);
        chk_idle("t41_pend_drained", 1'b1);
        send_b(1);
        chk_idle("t41_saturate", 1'b1);

        // reset in the middle of an 8-beat burst
        do_reset();
        fork
            drive_write(0, 32'h6000_0000, 4'd7);
            begin : rst_p
                int t;
                t = 0;
                do begin @(negedge clk); #1; t++; end while (w_hs < 3 && t < 100);
                chk("t42_beats_before_rst", w_hs, 64'd3);
                @(posedge clk); #1;
                rst = 1'b1;
                abort = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("t42_after_rst", {awvalid, wvalid, wlast, m0_wready, m0_awready, idle, bready},
                    7'b0000011);
            end
        join
        @(posedge clk); #1;
        abort = 1'b0;
        awq0.delete(); awq1.delete(); wq0.delete(); wq1.delete();
        clear_rec();
        rc = cyc;
        drive_write(1, 32'h7000_0000, 4'd1);
        chk_aw("t42_m1", 0, 4'd1, rc + 1);
        send_b(1);
        chk_idle("t42_idle", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
